// File: rtl/bmp_pkg.sv
// bmp_pkg: loader states, error codes, BMP header byte offsets and colour helper
package bmp_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, CALC, SKIP, PIXELS, PAD, DONE, ERROR} state_t;
  localparam logic [2:0] ERR_NONE = 3'd0, ERR_SIG = 3'd1, ERR_BPP = 3'd2, ERR_COMP = 3'd3,
                         ERR_OVERRUN = 3'd4, ERR_TRUNC = 3'd5;
  localparam int SIG = 0, OFFS = 10, WIDTH = 18, HEIGHT = 22, BPP = 28, COMP = 30;
  localparam logic [15:0] BM_SIG = 16'h4D42;
  function automatic logic [7:0] exp5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction
endpackage

// File: rtl/bmp_pix_unpack.sv
// bmp_pix_unpack: assembles 2/3/4 little-endian bytes (clk_sys, reset, clr, en, din, bpb_m1 in; done, xrgb out) into an xRGB8888 word
module bmp_pix_unpack
  import bmp_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  input  logic [1:0]  bpb_m1,
  output logic        done,
  output logic [31:0] xrgb
);
  logic [1:0] cnt_q, cnt_d, c;
  logic [7:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [15:0] p16;
  always_comb begin
    c = clr ? 2'd0 : cnt_q;
    done = en && c == bpb_m1;
    cnt_d = en ? (done ? 2'd0 : c + 2'd1) : c;
    b0_d = (en && c == 2'd0) ? din : b0_q;
    b1_d = (en && c == 2'd1) ? din : b1_q;
    b2_d = (en && c == 2'd2) ? din : b2_q;
    p16 = {din, b0_q};
    xrgb = bpb_m1 == 2'd1 ? {8'h00, exp5(p16[14:10]), exp5(p16[9:5]), exp5(p16[4:0])} :
           bpb_m1 == 2'd2 ? {8'h00, din, b1_q, b0_q} : {8'h00, b2_q, b1_q, b0_q};
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
    end
  end
endmodule

// File: rtl/bmp_stream_loader.sv
// bmp_stream_loader: parses a BMP ioctl byte stream and emits one framebuffer word write per visible pixel with loaded/error/size status
module bmp_stream_loader
  import bmp_pkg::*;
#(
  parameter int FB_WIDTH = 512,
  parameter int FB_HEIGHT = 312,
  parameter int FB_STRIDE = 512,
  parameter int ADDR_W = 22,
  parameter int BASE_ADDR = 0,
  parameter logic [7:0] INDEX = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_downl,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [31:0]       pix_data,
  output logic              busy,
  output logic              loaded,
  output logic [2:0]        error,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height
);
  state_t st_q, st_d;
  logic wr_q, dl_q, held_q, held_d, comp_q, comp_d, valid_q, valid_d, loaded_q, loaded_d;
  logic [15:0] sig_q, sig_d, width_q, width_d, bpp_q, bpp_d, col_q, col_d, row_q, row_d;
  logic [23:0] offs_q, offs_d;
  logic [31:0] height_q, height_d, data_q, data_d, xrgb;
  logic [1:0] pad_q, pad_d, padc_q, padc_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [2:0] err_q, err_d, bpb;
  logic [3:0] wb;
  logic [15:0] habs, first_row;
  logic idx_ok, dl, rise, fall, byte_ev, top_down, feed, pix_done, last_col, last_row, issue, adv;
  assign idx_ok = INDEX == 8'hFF || ioctl_index == INDEX;
  assign dl = ioctl_downl & idx_ok;
  assign rise = dl & ~dl_q;
  assign fall = ~dl & dl_q;
  assign byte_ev = ioctl_wr & ~wr_q & dl;
  assign top_down = height_q[31];
  assign habs = top_down ? 16'(-height_q) : height_q[15:0];
  assign first_row = top_down ? 16'd0 : habs - 16'd1;
  assign bpb = bpp_q[5:3];
  // Pad length only depends on the low two bits of the row byte count.
  assign wb = {2'b00, width_q[1:0]} * {1'b0, bpb};
  assign busy = !(st_q inside {IDLE, DONE, ERROR});
  // held_q replays a byte that landed during the single CALC cycle.
  assign feed = (st_q == SKIP && (byte_ev || held_q) && ioctl_addr == 25'(offs_q)) ||
                (st_q == PIXELS && byte_ev);
  assign last_col = col_q == width_q - 16'd1;
  assign last_row = top_down ? row_q == habs - 16'd1 : row_q == 16'd0;
  assign issue = pix_done && int'(col_q) < FB_WIDTH && int'(row_q) < FB_HEIGHT;
  assign adv = (pix_done && last_col && pad_q == 2'd0) || (st_q == PAD && byte_ev && padc_q == 2'd1);
  assign pix_valid = valid_q;
  assign pix_addr = addr_q;
  assign pix_data = data_q;
  assign loaded = loaded_q;
  assign error = err_q;
  assign img_width = width_q;
  assign img_height = habs;
  bmp_pix_unpack u_unpack (
    .clk_sys(clk_sys),
    .reset  (reset),
    .clr    (st_q != PIXELS),
    .en     (feed),
    .din    (ioctl_dout),
    .bpb_m1 (2'(bpb - 3'd1)),
    .done   (pix_done),
    .xrgb   (xrgb)
  );
  always_comb begin
    st_d = st_q;
    held_d = 1'b0;
    comp_d = comp_q;
    valid_d = valid_q & ~pix_ready;
    loaded_d = loaded_q;
    sig_d = sig_q;
    width_d = width_q;
    bpp_d = bpp_q;
    col_d = col_q;
    row_d = row_q;
    offs_d = offs_q;
    height_d = height_q;
    data_d = data_q;
    pad_d = pad_q;
    padc_d = padc_q;
    base_d = base_q;
    addr_d = addr_q;
    err_d = err_q;
    if (rise) begin
      st_d = HEADER;
      valid_d = 1'b0;
      loaded_d = 1'b0;
      err_d = ERR_NONE;
      comp_d = 1'b0;
      sig_d = '0;
      width_d = '0;
      bpp_d = '0;
      offs_d = '0;
      height_d = '0;
    end
    if ((st_q == HEADER || rise) && byte_ev) begin
      for (int i = 0; i < 2; i++) if (ioctl_addr == 25'(SIG + i)) sig_d[8*i +: 8] = ioctl_dout;
      for (int i = 0; i < 3; i++) if (ioctl_addr == 25'(OFFS + i)) offs_d[8*i +: 8] = ioctl_dout;
      for (int i = 0; i < 2; i++) if (ioctl_addr == 25'(WIDTH + i)) width_d[8*i +: 8] = ioctl_dout;
      for (int i = 0; i < 4; i++) if (ioctl_addr == 25'(HEIGHT + i)) height_d[8*i +: 8] = ioctl_dout;
      for (int i = 0; i < 2; i++) if (ioctl_addr == 25'(BPP + i)) bpp_d[8*i +: 8] = ioctl_dout;
      for (int i = 0; i < 4; i++) if (ioctl_addr == 25'(COMP + i) && ioctl_dout != 8'd0) comp_d = 1'b1;
      if (ioctl_addr == 25'(COMP + 3)) begin
        err_d = sig_d != BM_SIG ? ERR_SIG : !(bpp_d inside {16'd16, 16'd24, 16'd32}) ? ERR_BPP :
                comp_d ? ERR_COMP : ERR_NONE;
        st_d = err_d == ERR_NONE ? CALC : ERROR;
      end
    end
    if (st_q == CALC) begin
      held_d = byte_ev;
      base_d = ADDR_W'(BASE_ADDR + int'(first_row) * FB_STRIDE);
      row_d = first_row;
      col_d = '0;
      pad_d = 2'(4'd0 - wb);
      loaded_d = width_q == 16'd0 || habs == 16'd0;
      st_d = loaded_d ? DONE : SKIP;
    end
    if (st_q == SKIP && feed) st_d = PIXELS;
    if (pix_done) begin
      col_d = last_col ? 16'd0 : col_q + 16'd1;
      if (last_col && pad_q != 2'd0) begin
        st_d = PAD;
        padc_d = pad_q;
      end
    end
    if (st_q == PAD && byte_ev) padc_d = padc_q - 2'd1;
    if (adv) begin
      if (last_row) begin
        st_d = DONE;
        loaded_d = 1'b1;
      end else begin
        st_d = PIXELS;
        row_d = top_down ? row_q + 16'd1 : row_q - 16'd1;
        base_d = top_down ? base_q + ADDR_W'(FB_STRIDE) : base_q - ADDR_W'(FB_STRIDE);
      end
    end
    if (issue) begin
      if (valid_q && !pix_ready) begin
        st_d = ERROR;
        err_d = ERR_OVERRUN;
        loaded_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        addr_d = base_q + ADDR_W'(col_q);
        data_d = xrgb;
      end
    end
    if (fall && busy) begin
      st_d = ERROR;
      err_d = ERR_TRUNC;
      loaded_d = 1'b0;
    end
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      wr_q <= 1'b0;
      dl_q <= 1'b0;
      held_q <= 1'b0;
      comp_q <= 1'b0;
      valid_q <= 1'b0;
      loaded_q <= 1'b0;
      sig_q <= '0;
      width_q <= '0;
      bpp_q <= '0;
      col_q <= '0;
      row_q <= '0;
      offs_q <= '0;
      height_q <= '0;
      data_q <= '0;
      pad_q <= '0;
      padc_q <= '0;
      base_q <= '0;
      addr_q <= '0;
      err_q <= '0;
    end else begin
      st_q <= st_d;
      wr_q <= ioctl_wr;
      dl_q <= dl;
      held_q <= held_d;
      comp_q <= comp_d;
      valid_q <= valid_d;
      loaded_q <= loaded_d;
      sig_q <= sig_d;
      width_q <= width_d;
      bpp_q <= bpp_d;
      col_q <= col_d;
      row_q <= row_d;
      offs_q <= offs_d;
      height_q <= height_d;
      data_q <= data_d;
      pad_q <= pad_d;
      padc_q <= padc_d;
      base_q <= base_d;
      addr_q <= addr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_bmp_stream_loader.sv
// tb_bmp_stream_loader: directed self-checking bench for bmp_stream_loader
module tb_bmp_stream_loader;
  logic clk = 1'b0, reset, ioctl_downl, ioctl_wr, pix_valid, pix_ready, busy, loaded;
  logic [24:0] ioctl_addr;
  logic [7:0] ioctl_dout, ioctl_index;
  logic [21:0] pix_addr;
  logic [31:0] pix_data;
  logic [2:0] error;
  logic [15:0] img_width, img_height;
  logic [7:0] f[$];
  logic [21:0] wa[$];
  logic [31:0] wd[$];
  int n_chk = 0, n_err = 0;
  bmp_stream_loader dut (
    .clk_sys(clk), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_data(pix_data),
    .busy(busy), .loaded(loaded), .error(error), .img_width(img_width), .img_height(img_height)
  );
  initial forever #5 clk = ~clk;
  always @(negedge clk) if (pix_valid && pix_ready) begin
    wa.push_back(pix_addr);
    wd.push_back(pix_data);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic hdr(input logic [7:0] s1, input int w, input int h, input int bpp);
    f.delete();
    for (int i = 0; i < 54; i++) f.push_back(8'h00);
    f[0] = 8'h42;
    f[1] = s1;
    f[10] = 8'd54;
    f[14] = 8'd40;
    f[18] = w[7:0];
    f[19] = w[15:8];
    f[22] = h[7:0];
    f[23] = h[15:8];
    f[24] = h[23:16];
    f[25] = h[31:24];
    f[26] = 8'd1;
    f[28] = bpp[7:0];
  endtask
  task automatic send(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      ioctl_addr = 25'(i);
      ioctl_dout = f[i];
      ioctl_wr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ioctl_wr = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic start();
    @(negedge clk);
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk);
    wa.delete();
    wd.delete();
  endtask
  task automatic stop();
    @(negedge clk);
    ioctl_downl = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_index = 8'h03;
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    hdr(8'h4D, 4, 2, 24);
    for (int k = 0; k < 8; k++) begin
      f.push_back(8'(k));
      f.push_back(8'(8'h10 + k));
      f.push_back(8'(8'h20 + k));
    end
    start();
    chk("t1_busy_start", busy, 1);
    send(0, f.size());
    stop();
    chk("t1_count", wa.size(), 8);
    chk("t1_addr0", wa[0], 512);
    chk("t1_addr3", wa[3], 515);
    chk("t1_addr4", wa[4], 0);
    chk("t1_addr7", wa[7], 3);
    chk("t1_data0", wd[0], 32'h00201000);
    chk("t1_data7", wd[7], 32'h00271707);
    chk("t1_loaded", loaded, 1);
    chk("t1_error", error, 0);
    chk("t1_width", img_width, 4);
    chk("t1_height", img_height, 2);
    hdr(8'h4D, 3, 1, 24);
    f = {f, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hEE, 8'hEE, 8'hEE};
    start();
    chk("t2_loaded_clr", loaded, 0);
    send(0, 63);
    chk("t2_pad_busy", busy, 1);
    chk("t2_pad_loaded", loaded, 0);
    send(63, 66);
    chk("t2_loaded", loaded, 1);
    stop();
    chk("t2_count", wa.size(), 3);
    chk("t2_data0", wd[0], 32'h00332211);
    chk("t2_data1", wd[1], 32'h00665544);
    chk("t2_data2", wd[2], 32'h00998877);
    chk("t2_addr2", wa[2], 2);
    hdr(8'h4D, 2, 1, 16);
    f = {f, 8'h00, 8'h7C, 8'h21, 8'h04};
    start();
    send(0, f.size());
    stop();
    chk("t3_count", wa.size(), 2);
    chk("t3_red", wd[0], 32'h00FF0000);
    chk("t3_grey", wd[1], 32'h00080808);
    hdr(8'h4D, 600, -2, 16);
    for (int k = 0; k < 1200; k++) f = {f, 8'h1F, 8'h00};
    start();
    send(0, f.size());
    stop();
    chk("t4_count", wa.size(), 1024);
    chk("t4_addr0", wa[0], 0);
    chk("t4_addr511", wa[511], 511);
    chk("t4_addr512", wa[512], 512);
    chk("t4_addr1023", wa[1023], 1023);
    chk("t4_data", wd[1023], 32'h000000FF);
    chk("t4_height", img_height, 2);
    chk("t4_width", img_width, 600);
    chk("t4_loaded", loaded, 1);
    pix_ready = 1'b0;
    hdr(8'h4D, 2, 1, 24);
    f = {f, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    start();
    send(0, 57);
    chk("t5_pending", pix_valid, 1);
    send(57, 60);
    chk("t5_error", error, 4);
    chk("t5_kept_data", pix_data, 32'h00030201);
    chk("t5_kept_valid", pix_valid, 1);
    chk("t5_busy", busy, 0);
    pix_ready = 1'b1;
    send(60, 62);
    stop();
    chk("t5_error_hold", error, 4);
    chk("t5_drained", pix_valid, 0);
    hdr(8'h58, 4, 2, 24);
    start();
    send(0, 54);
    stop();
    chk("t6_sig", error, 1);
    chk("t6_nowrites", wa.size(), 0);
    hdr(8'h4D, 4, 2, 8);
    start();
    send(0, 54);
    stop();
    chk("t6_bpp", error, 2);
    hdr(8'h4D, 4, 2, 24);
    f[30] = 8'd1;
    start();
    send(0, 54);
    stop();
    chk("t6_comp", error, 3);
    hdr(8'h4D, 4, 2, 24);
    for (int k = 0; k < 24; k++) f.push_back(8'(k));
    start();
    send(0, 59);
    chk("t7_busy", busy, 1);
    stop();
    chk("t7_error", error, 5);
    chk("t7_loaded", loaded, 0);
    chk("t7_idle", busy, 0);
    pix_ready = 1'b0;
    start();
    send(0, 57);
    chk("t8_pending", pix_valid, 1);
    reset = 1'b1;
    ioctl_downl = 1'b0;
    @(negedge clk);
    chk("t8_valid", pix_valid, 0);
    chk("t8_busy", busy, 0);
    chk("t8_error", error, 0);
    chk("t8_width", img_width, 0);
    chk("t8_addr", pix_addr, 0);
    chk("t8_data", pix_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
